// File: rtl/buffer_arbiter_pkg.sv
// buffer_arbiter_pkg: shared widths, FSM state and owner encoding for the packet buffer arbiter.
package buffer_arbiter_pkg;
  localparam int FSMC_WIDTH = 16;
  localparam int BUF_ADDR_W = 12;
  localparam int BURST_LEN_W = 8;
  localparam int LENTH_BUFER = 1 << BUF_ADDR_W;
  localparam logic OWN_H = 1'b0;
  localparam logic OWN_L = 1'b1;
  typedef enum logic {IDLE, BURST} state_e;
endpackage

// File: rtl/buffer_rd_return.sv
// buffer_rd_return: aligns read owner tags with the buffer's registered read and captures RDATA.
module buffer_rd_return
  import buffer_arbiter_pkg::*;
#(
  parameter int DATA_W = FSMC_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_i,
  input  logic              own_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              h_rvalid_o,
  output logic              l_rvalid_o
);
  logic [1:0] v_q, own_q;
  logic h_rv_q, l_rv_q;
  logic [DATA_W-1:0] rdata_q;
  // stage 0 tracks the command register, stage 1 the buffer's output register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q <= '0;
      own_q <= '0;
      h_rv_q <= 1'b0;
      l_rv_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      v_q <= {v_q[0], rd_i};
      own_q <= {own_q[0], own_i};
      h_rv_q <= v_q[1] & (own_q[1] == OWN_H);
      l_rv_q <= v_q[1] & (own_q[1] == OWN_L);
      if (v_q[1]) rdata_q <= mem_data_i;
    end
  assign rdata_o = rdata_q;
  assign h_rvalid_o = h_rv_q;
  assign l_rvalid_o = l_rv_q;
endmodule

// File: rtl/buffer_arbiter.sv
// buffer_arbiter: round-robin burst arbiter sequencing H and L requesters onto the single-port buffer.
module buffer_arbiter
  import buffer_arbiter_pkg::*;
#(
  parameter int DATA_W = FSMC_WIDTH,
  parameter int ADDR_W = BUF_ADDR_W,
  parameter int LEN_W  = BURST_LEN_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              H_REQ,
  input  logic              L_REQ,
  input  logic              H_WE,
  input  logic              L_WE,
  input  logic [ADDR_W-1:0] H_ADDR,
  input  logic [ADDR_W-1:0] L_ADDR,
  input  logic [LEN_W-1:0]  H_LEN,
  input  logic [LEN_W-1:0]  L_LEN,
  input  logic [DATA_W-1:0] H_WDATA,
  input  logic [DATA_W-1:0] L_WDATA,
  output logic              H_GNT,
  output logic              L_GNT,
  output logic              H_WACK,
  output logic              L_WACK,
  output logic [DATA_W-1:0] H_RDATA,
  output logic [DATA_W-1:0] L_RDATA,
  output logic              H_RVALID,
  output logic              L_RVALID,
  output logic              BUSY,
  output logic              MEM_READ_WRITE,
  output logic [DATA_W-1:0] MEM_IN_DATA,
  output logic [15:0]       MEM_COLUMN_ADDR,
  output logic [15:0]       MEM_ROW_ADDR,
  input  logic [DATA_W-1:0] MEM_OUT_DATA
);
  state_e state_q, state_d;
  logic gap_q, gap_d, last_q, last_d, we_q, we_d, own_q, own_d, rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, sel_len;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata;
  logic idle, win_l, grant, issue, beat_own, beat_we, beat_wr, last_beat;
  // gap_q blocks a grant in the cycle right after a burst's final beat
  always_comb begin
    idle = state_q == IDLE;
    win_l = L_REQ & (~H_REQ | (last_q == OWN_H));
    grant = RESET & idle & ~gap_q & (H_REQ | L_REQ);
    issue = grant | ~idle;
    sel_len = win_l ? L_LEN : H_LEN;
    beat_own = idle ? win_l : own_q;
    beat_we = idle ? (win_l ? L_WE : H_WE) : we_q;
    beat_wr = issue & beat_we;
    last_beat = idle ? sel_len == '0 : cnt_q == LEN_W'(1);
    state_d = (grant & ~last_beat) ? BURST : (~idle & last_beat) ? IDLE : state_q;
    gap_d = issue & last_beat;
    cnt_d = grant ? sel_len : idle ? cnt_q : cnt_q - 1'b1;
    addr_d = grant ? (win_l ? L_ADDR : H_ADDR) : idle ? addr_q : addr_q + 1'b1;
    we_d = grant ? beat_we : we_q;
    own_d = grant ? win_l : own_q;
    last_d = grant ? win_l : last_q;
    rw_d = ~beat_wr;
    wdata_d = beat_wr ? (beat_own ? L_WDATA : H_WDATA) : wdata_q;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state_q <= IDLE;
      gap_q <= 1'b0;
      last_q <= OWN_L;
      we_q <= 1'b0;
      own_q <= OWN_H;
      cnt_q <= '0;
      addr_q <= '0;
      rw_q <= 1'b1;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q <= gap_d;
      last_q <= last_d;
      we_q <= we_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      rw_q <= rw_d;
      wdata_q <= wdata_d;
    end
  buffer_rd_return #(.DATA_W(DATA_W)) u_rd_return (
    .clk(CLK),
    .rst_n(RESET),
    .rd_i(issue & ~beat_we),
    .own_i(beat_own),
    .mem_data_i(MEM_OUT_DATA),
    .rdata_o(rdata),
    .h_rvalid_o(H_RVALID),
    .l_rvalid_o(L_RVALID)
  );
  assign H_GNT = grant & ~win_l;
  assign L_GNT = grant & win_l;
  assign H_WACK = beat_wr & (beat_own == OWN_H);
  assign L_WACK = beat_wr & (beat_own == OWN_L);
  assign H_RDATA = rdata;
  assign L_RDATA = rdata;
  assign BUSY = state_q == BURST;
  assign MEM_READ_WRITE = rw_q;
  assign MEM_IN_DATA = wdata_q;
  assign MEM_COLUMN_ADDR = 16'(addr_q);
  assign MEM_ROW_ADDR = '0;
endmodule

// File: tb/tb_buffer_arbiter.sv
// tb_buffer_arbiter: directed bursts against a behavioural single-port buffer with hand-computed expectations.
module tb_buffer_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req = '0, we = '0, gnt, wack, rv;
  logic [11:0] addr [2];
  logic [7:0] len [2];
  logic [15:0] wd [2];
  logic [15:0] h_rd, l_rd, mem_in, mem_out, col, row;
  logic mem_rw, busy;
  logic [15:0] mem [0:4095];
  logic [15:0] exp_mem [0:4095];
  logic init_q = 1'b0;
  int n_cmp = 0, n_err = 0, cyc = 0, nw, t;
  int gcyc [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  buffer_arbiter dut (
    .CLK(clk), .RESET(rst_n),
    .H_REQ(req[0]), .L_REQ(req[1]), .H_WE(we[0]), .L_WE(we[1]),
    .H_ADDR(addr[0]), .L_ADDR(addr[1]), .H_LEN(len[0]), .L_LEN(len[1]),
    .H_WDATA(wd[0]), .L_WDATA(wd[1]), .H_GNT(gnt[0]), .L_GNT(gnt[1]),
    .H_WACK(wack[0]), .L_WACK(wack[1]), .H_RDATA(h_rd), .L_RDATA(l_rd),
    .H_RVALID(rv[0]), .L_RVALID(rv[1]), .BUSY(busy),
    .MEM_READ_WRITE(mem_rw), .MEM_IN_DATA(mem_in), .MEM_COLUMN_ADDR(col),
    .MEM_ROW_ADDR(row), .MEM_OUT_DATA(mem_out)
  );

  function automatic logic [15:0] pat(input int i);
    return 16'h5A00 ^ 16'(i);
  endfunction

  // buffer model: writes on every edge with READ_WRITE low, registered read
  always @(posedge clk) begin
    if (!init_q) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
      init_q <= 1'b1;
    end else if (!mem_rw) mem[col[11:0]] <= mem_in;
    mem_out <= mem[col[11:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_gnt(input int r, input string tag);
    int w = 0;
    @(negedge clk);
    while (!gnt[r] && w < 60) begin @(negedge clk); w++; end
    chk(tag, 32'(gnt[r]), 1);
    gcyc[r] = cyc;
  endtask

  task automatic wr_burst(input int r, input logic [11:0] a, input logic [7:0] n, input logic [15:0] d0);
    @(posedge clk); #1;
    req[r] = 1'b1; we[r] = 1'b1; addr[r] = a; len[r] = n; wd[r] = d0;
    wait_gnt(r, "wr_gnt");
    for (int k = 0; k <= int'(n); k++) begin
      chk("wack", 32'(wack[r]), 1);
      exp_mem[a + 12'(k)] = d0 + 16'(k);
      @(posedge clk); #1;
      req[r] = 1'b0; wd[r] = d0 + 16'(k + 1);
      @(negedge clk);
    end
    chk("wack_gap", 32'(wack[r]), 0);
  endtask

  task automatic rd_burst(input int r, input logic [11:0] a, input logic [7:0] n);
    int cnt = 0;
    bit want;
    @(posedge clk); #1;
    req[r] = 1'b1; we[r] = 1'b0; addr[r] = a; len[r] = n;
    wait_gnt(r, "rd_gnt");
    for (int j = 0; j <= int'(n) + 4; j++) begin
      want = j >= 3 && j <= int'(n) + 3;
      chk("rvalid", 32'(rv[r]), 32'(want));
      chk("rvalid_other", 32'(rv[1-r]), 0);
      if (want) chk("rdata", 32'(r ? l_rd : h_rd), 32'(exp_mem[a + 12'(j - 3)]));
      cnt += int'(rv[r]);
      @(posedge clk); #1;
      req[r] = 1'b0;
      @(negedge clk);
    end
    chk("rd_pulses", 32'(cnt), 32'(int'(n) + 1));
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) exp_mem[i] = pat(i);
    for (int i = 0; i < 2; i++) begin addr[i] = '0; len[i] = '0; wd[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rw", 32'(mem_rw), 1);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_rw", 32'(mem_rw), 1);
      chk("idle_out", {26'd0, gnt, wack, rv}, 0);
    end
    chk("idle_col_hi", 32'(col[15:12]), 0);
    chk("idle_row", 32'(row), 0);
    chk("idle_mem0", 32'(mem[0]), 32'(pat(0)));

    wr_burst(0, 12'h010, 8'd3, 16'hA000);
    @(negedge clk);
    chk("wr_0x010", 32'(mem[12'h010]), 32'hA000);
    chk("wr_0x013", 32'(mem[12'h013]), 32'hA003);
    chk("wr_0x014", 32'(mem[12'h014]), 32'(pat(12'h014)));
    rd_burst(0, 12'h010, 8'd3);

    do_reset();
    fork
      wr_burst(0, 12'h100, 8'd1, 16'hB000);
      wr_burst(1, 12'h200, 8'd2, 16'hC000);
    join
    chk("conf1_l_after_h", 32'(gcyc[1] - gcyc[0]), 3);
    fork
      wr_burst(0, 12'h300, 8'd0, 16'hB100);
      wr_burst(1, 12'h400, 8'd0, 16'hC100);
    join
    chk("conf2_h_first", 32'(gcyc[1] - gcyc[0]), 2);
    wr_burst(0, 12'h500, 8'd0, 16'hB200);
    fork
      wr_burst(0, 12'h700, 8'd0, 16'hB300);
      wr_burst(1, 12'h600, 8'd0, 16'hC300);
    join
    chk("conf3_l_first", 32'(gcyc[0] - gcyc[1]), 2);
    @(negedge clk);
    chk("conf_0x201", 32'(mem[12'h201]), 32'hC001);
    chk("conf_0x700", 32'(mem[12'h700]), 32'hB300);

    wr_burst(1, 12'hFFE, 8'd3, 16'hD000);
    @(negedge clk);
    chk("wrap_0xFFF", 32'(mem[12'hFFF]), 32'hD001);
    chk("wrap_0x000", 32'(mem[12'h000]), 32'hD002);
    chk("wrap_0x001", 32'(mem[12'h001]), 32'hD003);
    chk("wrap_0x002", 32'(mem[12'h002]), 32'(pat(2)));
    rd_burst(1, 12'hFFE, 8'd3);

    nw = 0;
    fork
      rd_burst(0, 12'h010, 8'd7);
      begin
        t = 0;
        while (!gnt[0] && t < 60) begin @(negedge clk); t++; end
        wr_burst(1, 12'h800, 8'd1, 16'hE100);
      end
      for (int i = 0; i < 40 && !gnt[1]; i++) begin
        @(negedge clk);
        if (!mem_rw) nw++;
      end
    join
    chk("rd_then_wr_gnt", 32'(gcyc[1] - gcyc[0]), 9);
    chk("no_early_write", 32'(nw), 0);

    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 12'h900; len[0] = 8'd3; wd[0] = 16'hE000;
    @(negedge clk);
    chk("rst_burst_gnt", 32'(gnt[0]), 1);
    @(posedge clk); #1;
    req[0] = 1'b0; wd[0] = 16'hE001;
    @(negedge clk);
    chk("rst_beat0_pending", 32'(mem_rw), 0);
    rst_n = 1'b0;
    #1;
    chk("arst_rw", 32'(mem_rw), 1);
    chk("arst_wack", 32'(wack[0]), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_col", 32'(col), 0);
    chk("arst_din", 32'(mem_in), 0);
    req[1] = 1'b1;
    #1;
    chk("arst_gnt_held", 32'(gnt[1]), 0);
    req[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    chk("rst_0x900_kept", 32'(mem[12'h900]), 32'(pat(12'h900)));
    chk("rst_0x000_kept", 32'(mem[12'h000]), 32'hD002);
    wr_burst(0, 12'h900, 8'd1, 16'hF000);
    @(negedge clk);
    chk("post_rst_0x900", 32'(mem[12'h900]), 32'hF000);
    chk("post_rst_0x901", 32'(mem[12'h901]), 32'hF001);
    rd_burst(0, 12'h8FF, 8'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
